// File: rtl/ahb_uart_pkg.sv
// Shared constants and state encodings for the UART-to-AHB-Lite bridge.
package ahb_uart_pkg;

   localparam logic [7:0] CMD_WR = 8'hA3;
   localparam logic [7:0] CMD_RD = 8'hA5;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [3:0] HPROT_DATA    = 4'b0011;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StWdata,
      StAhbA,
      StAhbD,
      StTx
   } state_e;

   typedef enum logic [1:0] {
      RxIdle,
      RxStart,
      RxData,
      RxStop
   } rx_state_e;

endpackage

// File: rtl/ahb_uart_phy.sv
// 8N1 UART deserialiser and serialiser sharing one bit period of BAUD_CNT clock cycles.
module ahb_uart_phy
   import ahb_uart_pkg::*;
#(
   parameter int unsigned BAUD_CNT = 20833
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic       tx_o,
   output logic       rx_valid_o,
   output logic [7:0] rx_data_o,
   output logic       rx_ferr_o,
   input  logic       tx_start_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_busy_o
);

   localparam logic [15:0] BitEnd  = 16'(BAUD_CNT - 1);
   localparam logic [15:0] HalfEnd = 16'(BAUD_CNT / 2 - 1);

   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;

   logic        tx_busy_q, tx_busy_d;
   logic [9:0]  tx_shift_q, tx_shift_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]  tx_idx_q, tx_idx_d;
   logic        tx_bit_end, tx_last;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         tx_busy_q  <= 1'b0;
         tx_shift_q <= '1;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
      end else begin
         rx_s1_q    <= rx_i;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         tx_busy_q  <= tx_busy_d;
         tx_shift_q <= tx_shift_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 16'd1;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid_o = 1'b0;
      rx_ferr_o  = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s2_q) rx_state_d = RxStart;
         end
         RxStart: begin
            // A start bit that is high again at mid-bit was a glitch.
            if (rx_cnt_q == HalfEnd) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s2_q ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (rx_cnt_q == BitEnd) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RxStop;
            end
         end
         RxStop: begin
            if (rx_cnt_q == BitEnd) begin
               rx_valid_o = rx_s2_q;
               rx_ferr_o  = !rx_s2_q;
               rx_state_d = RxIdle;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   assign rx_data_o = rx_shift_q;

   // The final stop-bit cycle reports not-busy so a queued frame follows with no gap.
   assign tx_bit_end = (tx_cnt_q == BitEnd);
   assign tx_last    = tx_busy_q && tx_bit_end && (tx_idx_q == 4'd9);
   assign tx_busy_o  = tx_busy_q && !tx_last;

   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_shift_d = tx_shift_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      if (tx_busy_q) begin
         tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 16'd1;
         if (tx_bit_end) begin
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_idx_d   = tx_idx_q + 4'd1;
         end
         if (tx_last) tx_busy_d = 1'b0;
      end
      if (tx_start_i && !tx_busy_o) begin
         tx_busy_d  = 1'b1;
         tx_shift_d = {1'b1, tx_data_i, 1'b0};
         tx_cnt_d   = '0;
         tx_idx_d   = '0;
      end
   end

   assign tx_o = tx_busy_q ? tx_shift_q[0] : 1'b1;

endmodule

// File: rtl/ahb_uart_master.sv
// UART command decoder driving single-word AHB-Lite transfers; read data is returned over UART.
module ahb_uart_master
   import ahb_uart_pkg::*;
#(
   parameter int unsigned BAUD_CNT     = 20833,
   parameter int unsigned TIMEOUT_BITS = 40,
   parameter logic [31:0] ERR_RDATA    = 32'hDEADBEEF
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        UART_MASTER_RX,
   output logic        UART_MASTER_TX,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   input  logic        HREADY,
   input  logic [31:0] HRDATA,
   input  logic        HRESP
);

   localparam logic [31:0] TimeoutEnd = 32'(TIMEOUT_BITS * BAUD_CNT - 1);

   logic        rx_valid, rx_ferr, tx_start, tx_busy;
   logic [7:0]  rx_data, tx_data;

   state_e      state_q, state_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] tmo_q, tmo_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  txb_q, txb_d;
   logic [31:0] haddr_q, haddr_d;
   logic        hwrite_q, hwrite_d;
   logic [31:0] hwdata_q, hwdata_d;

   ahb_uart_phy #(
      .BAUD_CNT(BAUD_CNT)
   ) u_phy (
      .clk_i     (HCLK),
      .rst_ni    (HRESETn),
      .rx_i      (UART_MASTER_RX),
      .tx_o      (UART_MASTER_TX),
      .rx_valid_o(rx_valid),
      .rx_data_o (rx_data),
      .rx_ferr_o (rx_ferr),
      .tx_start_i(tx_start),
      .tx_data_i (tx_data),
      .tx_busy_o (tx_busy)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= StIdle;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         lane_q   <= '0;
         tmo_q    <= '0;
         rdata_q  <= '0;
         txb_q    <= '0;
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         hwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         lane_q   <= lane_d;
         tmo_q    <= tmo_d;
         rdata_q  <= rdata_d;
         txb_q    <= txb_d;
         haddr_q  <= haddr_d;
         hwrite_q <= hwrite_d;
         hwdata_q <= hwdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      lane_d   = lane_q;
      tmo_d    = tmo_q;
      rdata_d  = rdata_q;
      txb_d    = txb_q;
      haddr_d  = haddr_q;
      hwrite_d = hwrite_q;
      hwdata_d = hwdata_q;
      tx_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            lane_d = '0;
            tmo_d  = '0;
            if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
               write_d = (rx_data == CMD_WR);
               state_d = StAddr;
            end
         end
         StAddr, StWdata: begin
            tmo_d = tmo_q + 32'd1;
            if (rx_ferr || tmo_q == TimeoutEnd) begin
               state_d = StIdle;
            end else if (rx_valid) begin
               tmo_d  = '0;
               lane_d = lane_q + 2'd1;
               if (state_q == StAddr) addr_d[{lane_q, 3'b000} +: 8] = rx_data;
               else                   wdata_d[{lane_q, 3'b000} +: 8] = rx_data;
               if (lane_q == 2'd3) begin
                  if (state_q == StAddr && write_q) begin
                     state_d = StWdata;
                  end else begin
                     state_d  = StAhbA;
                     haddr_d  = {addr_d[31:2], 2'b00};
                     hwrite_d = write_q;
                  end
               end
            end
         end
         StAhbA: begin
            if (HREADY) begin
               state_d = StAhbD;
               if (write_q) hwdata_d = wdata_q;
            end
         end
         StAhbD: begin
            if (HREADY) begin
               if (write_q) begin
                  state_d = StIdle;
               end else begin
                  rdata_d = HRESP ? ERR_RDATA : HRDATA;
                  txb_d   = '0;
                  state_d = StTx;
               end
            end
         end
         StTx: begin
            tx_start = 1'b1;
            if (!tx_busy) begin
               txb_d = txb_q + 2'd1;
               if (txb_q == 2'd3) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign tx_data = rdata_q[{txb_q, 3'b000} +: 8];

   assign HTRANS = (state_q == StAhbA) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HADDR  = haddr_q;
   assign HWRITE = hwrite_q;
   assign HWDATA = hwdata_q;
   assign HSIZE  = HSIZE_WORD;
   assign HBURST = HBURST_SINGLE;
   assign HPROT  = HPROT_DATA;

endmodule

// File: tb/tb_ahb_uart_master.sv
// Directed bench: UART command vectors against an AHB slave model and a UART receiver.
module tb_ahb_uart_master;

   localparam int unsigned BAUD  = 16;
   localparam int unsigned TBITS = 40;

   logic        HCLK;
   logic        HRESETn;
   logic        rx;
   logic        tx;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HRESP;

   ahb_uart_master #(
      .BAUD_CNT    (BAUD),
      .TIMEOUT_BITS(TBITS),
      .ERR_RDATA   (32'hDEADBEEF)
   ) dut (
      .HCLK          (HCLK),
      .HRESETn       (HRESETn),
      .UART_MASTER_RX(rx),
      .UART_MASTER_TX(tx),
      .HADDR         (HADDR),
      .HTRANS        (HTRANS),
      .HSIZE         (HSIZE),
      .HBURST        (HBURST),
      .HPROT         (HPROT),
      .HWRITE        (HWRITE),
      .HWDATA        (HWDATA),
      .HREADY        (HREADY),
      .HRDATA        (HRDATA),
      .HRESP         (HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [95:0] bytes;
      int          nbytes;
      int          bad_stop;
      int          waits;
      logic        resp;
      logic [31:0] rdata;
      int          exp_xfers;
      logic [31:0] exp_addr;
      logic        exp_write;
      logic [31:0] exp_wdata;
      int          exp_ntx;
      logic [31:0] exp_tx;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          xfers;
   int          sl_waits = 0;
   logic        sl_resp  = 1'b0;
   logic [31:0] sl_rdata = '0;
   logic [31:0] sl_a;
   logic [31:0] cap_addr, cap_wdata;
   logic        cap_write;
   logic [2:0]  cap_size, cap_burst;
   logic [3:0]  cap_prot;
   logic [7:0]  txq[$];
   logic [7:0]  rb;
   vec_t        vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [95:0] b, input int n, input int bad, input int w,
                               input logic resp, input logic [31:0] rd, input int xf,
                               input logic [31:0] ea, input logic ew, input logic [31:0] ewd,
                               input int ntx, input logic [31:0] etx);
      vec_t v;
      v.bytes = b;     v.nbytes = n;     v.bad_stop = bad;  v.waits = w;
      v.resp = resp;   v.rdata = rd;     v.exp_xfers = xf;  v.exp_addr = ea;
      v.exp_write = ew; v.exp_wdata = ewd; v.exp_ntx = ntx; v.exp_tx = etx;
      return v;
   endfunction

   // AHB slave: wait states in both phases, checks address-phase stability.
   initial begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = '0;
      forever begin
         @(negedge HCLK);
         if (HRESETn && HTRANS == 2'b10) begin
            sl_a = HADDR;
            for (int i = 0; i < sl_waits; i++) begin
               HREADY = 1'b0;
               @(negedge HCLK);
               check("htrans_wait", 32'(HTRANS), 32'h2);
               check("haddr_wait", HADDR, sl_a);
            end
            HREADY    = 1'b1;
            xfers++;
            cap_addr  = HADDR;
            cap_write = HWRITE;
            cap_size  = HSIZE;
            cap_burst = HBURST;
            cap_prot  = HPROT;
            @(negedge HCLK);
            check("htrans_dphase", 32'(HTRANS), 32'h0);
            for (int i = 0; i < sl_waits; i++) begin
               HREADY = 1'b0;
               @(negedge HCLK);
            end
            HREADY    = 1'b1;
            HRDATA    = sl_rdata;
            HRESP     = sl_resp;
            cap_wdata = HWDATA;
            @(negedge HCLK);
            HRESP  = 1'b0;
            HRDATA = '0;
         end
      end
   end

   // UART receiver for the DUT's TX line.
   initial begin
      forever begin
         @(negedge tx);
         repeat (BAUD / 2) @(posedge HCLK);
         #1;
         if (tx == 1'b0) begin
            rb = '0;
            for (int i = 0; i < 8; i++) begin
               repeat (BAUD) @(posedge HCLK);
               #1;
               rb[i] = tx;
            end
            repeat (BAUD) @(posedge HCLK);
            #1;
            txq.push_back(rb);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (BAUD) @(negedge HCLK);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BAUD) @(negedge HCLK);
      end
      rx = stop;
      repeat (BAUD) @(negedge HCLK);
      rx = 1'b1;
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int   cyc;
      logic [31:0] word;
      xfers = 0;
      txq.delete();
      sl_waits = v.waits;
      sl_resp  = v.resp;
      sl_rdata = v.rdata;
      for (int k = 0; k < v.nbytes; k++) send_byte(v.bytes[8*k +: 8], k != v.bad_stop);
      cyc = 0;
      while (txq.size() < v.exp_ntx && cyc < 3000) begin
         @(negedge HCLK);
         cyc++;
      end
      repeat (200) @(negedge HCLK);
      check($sformatf("v%0d_xfers", id), 32'(xfers), 32'(v.exp_xfers));
      if (v.exp_xfers > 0) begin
         check($sformatf("v%0d_haddr", id), cap_addr, v.exp_addr);
         check($sformatf("v%0d_hwrite", id), 32'(cap_write), 32'(v.exp_write));
         check($sformatf("v%0d_hsize", id), 32'(cap_size), 32'h2);
         check($sformatf("v%0d_hburst", id), 32'(cap_burst), 32'h0);
         check($sformatf("v%0d_hprot", id), 32'(cap_prot), 32'h3);
         if (v.exp_write) check($sformatf("v%0d_hwdata", id), cap_wdata, v.exp_wdata);
      end
      check($sformatf("v%0d_txcount", id), 32'(txq.size()), 32'(v.exp_ntx));
      if (v.exp_ntx == 4 && txq.size() == 4) begin
         word = {txq[3], txq[2], txq[1], txq[0]};
         check($sformatf("v%0d_txdata", id), word, v.exp_tx);
      end
   endtask

   initial begin
      int cyc;
      vecs[0] = mk(96'hA5A855014C000014A3, 9, -1, 0, 1'b0, 32'h0, 1, 32'h4C000014, 1'b1,
                   32'hA5A85501, 0, 32'h0);
      vecs[1] = mk(96'h4C000018A5, 5, -1, 3, 1'b0, 32'h12345678, 1, 32'h4C000018, 1'b0,
                   32'h0, 4, 32'h12345678);
      vecs[2] = mk(96'hA5A855014C000014A3FF00, 11, -1, 1, 1'b0, 32'h0, 1, 32'h4C000014, 1'b1,
                   32'hA5A85501, 0, 32'h0);
      vecs[3] = mk(96'hA5A855014C000017A3, 9, -1, 0, 1'b0, 32'h0, 1, 32'h4C000014, 1'b1,
                   32'hA5A85501, 0, 32'h0);
      vecs[4] = mk(96'h000018A5, 4, 3, 0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 32'h0, 0, 32'h0);
      vecs[5] = mk(96'h4C000018A5, 5, -1, 2, 1'b1, 32'h12345678, 1, 32'h4C000018, 1'b0,
                   32'h0, 4, 32'hDEADBEEF);
      vecs[6] = mk(96'h4C000020A5, 5, -1, 0, 1'b0, 32'hCAFEF00D, 1, 32'h4C000020, 1'b0,
                   32'h0, 4, 32'hCAFEF00D);

      rx      = 1'b1;
      HRESETn = 1'b1;
      #2 HRESETn = 1'b0;
      repeat (3) @(negedge HCLK);
      check("rst_tx", 32'(tx), 32'h1);
      check("rst_htrans", 32'(HTRANS), 32'h0);
      check("rst_haddr", HADDR, 32'h0);
      check("rst_hwrite", 32'(HWRITE), 32'h0);
      check("rst_hwdata", HWDATA, 32'h0);
      check("rst_hsize", 32'(HSIZE), 32'h2);
      check("rst_hburst", 32'(HBURST), 32'h0);
      check("rst_hprot", 32'(HPROT), 32'h3);
      HRESETn = 1'b1;
      repeat (5) @(negedge HCLK);

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Partial write command, then silence past the inter-byte timeout.
      xfers = 0;
      send_byte(8'hA3, 1'b1);
      send_byte(8'h14, 1'b1);
      send_byte(8'h00, 1'b1);
      repeat ((TBITS + 1) * BAUD) @(negedge HCLK);
      check("tmo_no_xfer", 32'(xfers), 32'h0);
      run_vec(10, vecs[1]);

      // Reset in the middle of the second reply byte.
      xfers    = 0;
      txq.delete();
      sl_waits = 0;
      sl_resp  = 1'b0;
      sl_rdata = 32'h12345678;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h18, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h4C, 1'b1);
      cyc = 0;
      while (txq.size() < 1 && cyc < 2000) begin
         @(negedge HCLK);
         cyc++;
      end
      check("rst6_first_byte", 32'(txq.size()), 32'h1);
      repeat (32) @(negedge HCLK);
      check("rst6_tx_low_before", 32'(tx), 32'h0);
      HRESETn = 1'b0;
      #1;
      check("rst6_tx_high", 32'(tx), 32'h1);
      check("rst6_htrans", 32'(HTRANS), 32'h0);
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      repeat (12 * BAUD) @(negedge HCLK);
      run_vec(11, vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
